// File: rtl/scanline_prefetch.sv
// Scanline fetcher: fills the ping-pong line RAM with line N+1 from SDRAM while line N is displayed.
// Pixel path has 2 cycles latency; one SDRAM word per REQ/GAP pair, REQ held until sdram_ack.
module scanline_prefetch #(
    parameter int DATA_W   = 128,
    parameter int PIX_W    = 8,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int ADDR_W   = 22,
    parameter logic [ADDR_W-1:0] FB0_BASE = 'h100000,
    parameter logic [ADDR_W-1:0] FB1_BASE = 'h200000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic              new_frame,
    input  logic              flip_req,
    input  logic              scale_en,
    input  logic              sdram_wait,
    input  logic              sdram_ack,
    input  logic [DATA_W-1:0] sdram_data,
    output logic              sdram_rd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [PIX_W-1:0]  pix_index,
    output logic              pix_valid,
    output logic              front_buf,
    output logic              busy,
    output logic              done,
    output logic              underrun
);
    localparam int PPW = DATA_W / PIX_W;
    localparam int WPL = H_ACTIVE / PPW;
    localparam int XS  = $clog2(PPW);
    localparam int WW  = $clog2(WPL);
    localparam int IW  = $clog2(2 * WPL);

    localparam logic [9:0]        H_LIM  = 10'(H_ACTIVE);
    localparam logic [9:0]        V_LIM  = 10'(V_ACTIVE);
    localparam logic [9:0]        Y_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]        WPL_X  = 10'(WPL);
    localparam logic [WW-1:0]     W_LAST = WW'(WPL - 1);
    localparam logic [ADDR_W-1:0] WPL_A  = ADDR_W'(WPL);
    localparam logic [IW-1:0]     WPL_I  = IW'(WPL);

    typedef enum logic [2:0] {IDLE, PEND, REQ, GAP, LINE_DONE, FRAME_DONE} state_t;

    state_t            state;
    logic [9:0]        prev_y;
    logic [9:0]        fetch_t;
    logic [9:0]        fetch_s;
    logic [WW-1:0]     w;

    logic [9:0]        tgt;
    logic [9:0]        src;
    logic              line_start;
    logic              fetch_ok;
    logic              in_fetch;
    logic [ADDR_W-1:0] base;

    assign line_start = (draw_y != prev_y);
    assign tgt        = (draw_y == Y_LAST) ? 10'd0 : draw_y + 10'd1;
    assign src        = scale_en ? {1'b0, tgt[9:1]} : tgt;
    // In scale mode odd target lines reuse the bank filled for the even line above.
    assign fetch_ok   = (tgt < V_LIM) && (!scale_en || !tgt[0]);
    assign in_fetch   = (state == PEND) || (state == REQ) || (state == GAP);
    assign base       = front_buf ? FB1_BASE : FB0_BASE;

    // Line RAM: bank b occupies words [b*WPL, b*WPL+WPL-1]
    logic [DATA_W-1:0] line_ram [2*WPL];
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic [9:0]        word_x;
    logic              rd_bank;
    logic [DATA_W-1:0] rd_word;
    logic [XS-1:0]     rd_sel;
    logic              rd_vis;

    assign wr_idx  = (fetch_s[0] ? WPL_I : '0) + IW'(w);
    assign rd_bank = scale_en ? draw_y[1] : draw_y[0];
    assign word_x  = draw_x >> XS;
    assign rd_idx  = (word_x < WPL_X) ? ((rd_bank ? WPL_I : '0) + IW'(word_x)) : '0;

    always_ff @(posedge clock) begin
        if (state == REQ && sdram_ack) begin
            line_ram[wr_idx] <= sdram_data;
        end
        rd_word <= line_ram[rd_idx];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_sel    <= '0;
            rd_vis    <= 1'b0;
            pix_index <= '0;
            pix_valid <= 1'b0;
        end else begin
            rd_sel    <= draw_x[XS-1:0];
            rd_vis    <= (draw_x < H_LIM) && (draw_y < V_LIM);
            pix_valid <= rd_vis;
            pix_index <= rd_vis ? rd_word[rd_sel*PIX_W +: PIX_W] : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            prev_y     <= draw_y;
            fetch_t    <= '0;
            fetch_s    <= '0;
            w          <= '0;
            sdram_rd   <= 1'b0;
            sdram_addr <= '0;
            front_buf  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            prev_y <= draw_y;
            if (new_frame) begin
                state     <= IDLE;
                front_buf <= front_buf ^ flip_req;
                underrun  <= 1'b0;
                sdram_rd  <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b0;
            end else if (line_start && (state == IDLE || in_fetch)) begin
                // A fetch still running here is late: abandon it and retarget at once.
                if (in_fetch) begin
                    underrun <= 1'b1;
                end
                sdram_rd <= 1'b0;
                if (fetch_ok) begin
                    state   <= PEND;
                    busy    <= 1'b1;
                    fetch_t <= tgt;
                    fetch_s <= src;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    PEND: begin
                        if (!sdram_wait) begin
                            w          <= '0;
                            state      <= REQ;
                            sdram_rd   <= 1'b1;
                            sdram_addr <= base + ADDR_W'(fetch_s) * WPL_A;
                        end
                    end
                    REQ: begin
                        if (sdram_ack) begin
                            sdram_rd <= 1'b0;
                            if (w == W_LAST) begin
                                state <= LINE_DONE;
                                busy  <= 1'b0;
                            end else begin
                                w          <= w + 1'b1;
                                sdram_addr <= sdram_addr + 1'b1;
                                state      <= GAP;
                            end
                        end
                    end
                    GAP: begin
                        state    <= REQ;
                        sdram_rd <= 1'b1;
                    end
                    LINE_DONE: begin
                        if (fetch_t == V_LIM - 10'd1) begin
                            state <= FRAME_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_scanline_prefetch.sv
// Bench for scanline_prefetch: SDRAM responder process plus address and pixel scoreboards.
module tb_scanline_prefetch;
    localparam int DATA_W   = 128;
    localparam int PIX_W    = 8;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;
    localparam int ADDR_W   = 22;
    localparam int PPW      = DATA_W / PIX_W;
    localparam int WPL      = H_ACTIVE / PPW;
    localparam logic [ADDR_W-1:0] FB0 = 22'h100000;
    localparam logic [ADDR_W-1:0] FB1 = 22'h200000;

    logic              clock = 1'b0;
    logic              reset;
    logic [9:0]        draw_x, draw_y;
    logic              new_frame, flip_req, scale_en, sdram_wait, sdram_ack;
    logic [DATA_W-1:0] sdram_data;
    logic              sdram_rd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [PIX_W-1:0]  pix_index;
    logic              pix_valid, front_buf, busy, done, underrun;

    int total = 0;
    int bad   = 0;
    int ack_div = 3;

    logic [ADDR_W-1:0] got_q[$];
    logic [ADDR_W-1:0] exp_q[$];
    logic [PIX_W:0]    pix_q[$];

    always #5 clock = ~clock;

    scanline_prefetch #(
        .DATA_W(DATA_W), .PIX_W(PIX_W), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
        .V_TOTAL(V_TOTAL), .ADDR_W(ADDR_W), .FB0_BASE(FB0), .FB1_BASE(FB1)
    ) dut (
        .clock(clock), .reset(reset), .draw_x(draw_x), .draw_y(draw_y),
        .new_frame(new_frame), .flip_req(flip_req), .scale_en(scale_en),
        .sdram_wait(sdram_wait), .sdram_ack(sdram_ack), .sdram_data(sdram_data),
        .sdram_rd(sdram_rd), .sdram_addr(sdram_addr), .pix_index(pix_index),
        .pix_valid(pix_valid), .front_buf(front_buf), .busy(busy), .done(done),
        .underrun(underrun)
    );

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 8; i++) begin
            d[i*8 +: 8] = 8'(int'(a[7:0]) * 29 + i * 37 + int'(a[15:8]) + int'(a[21:16]) * 3);
        end
        return d;
    endfunction

    function automatic logic [PIX_W:0] exp_pix(input int x, input int y,
                                               input logic [ADDR_W-1:0] base, input int src);
        logic [DATA_W-1:0] d;
        if (x < H_ACTIVE && y < V_ACTIVE) begin
            d = mem_word(base + ADDR_W'(src * WPL + x / PPW));
            return {1'b1, d[(x % PPW) * PIX_W +: PIX_W]};
        end
        return '0;
    endfunction

    // SDRAM model: acks every ack_div-th cycle of a held request (never when ack_div = 0)
    initial begin
        int cnt;
        cnt = 0;
        sdram_ack = 1'b0;
        sdram_data = '0;
        forever begin
            @(negedge clock);
            if (sdram_rd && !reset) begin
                cnt++;
                if (ack_div != 0 && cnt % ack_div == 0) begin
                    sdram_ack  = 1'b1;
                    sdram_data = mem_word(sdram_addr);
                    got_q.push_back(sdram_addr);
                end else begin
                    sdram_ack = 1'b0;
                end
            end else begin
                cnt = 0;
                sdram_ack = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic set_line(input int y);
        @(posedge clock); #1;
        draw_y = 10'(y);
    endtask

    task automatic pulse_frame(input logic flip);
        @(posedge clock); #1;
        new_frame = 1'b1;
        flip_req  = flip;
        @(posedge clock); #1;
        new_frame = 1'b0;
        flip_req  = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(posedge clock);
        @(negedge clock);
        while (busy && k < 2000) begin
            @(negedge clock);
            k++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: busy=%0b after %0d cycles, required 0", name, busy, k);
        end
    endtask

    task automatic check_addrs(input string name);
        logic [ADDR_W-1:0] e, g;
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s count: got %0d reads, required %0d", name, got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL %s addr: got %h, required %h", name, g, e);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic sweep_line(input int y, input logic [ADDR_W-1:0] base, input string name);
        int src;
        logic [PIX_W:0] e;
        src = scale_en ? (y >> 1) : y;
        for (int c = 0; c < H_ACTIVE + 6; c++) begin
            @(posedge clock); #1;
            if (c < H_ACTIVE + 4) begin
                draw_x = 10'(c);
                pix_q.push_back(exp_pix(c, y, base, src));
            end else begin
                draw_x = 10'd1000;
            end
            @(negedge clock);
            if (c >= 2) begin
                e = pix_q.pop_front();
                total++;
                if ({pix_valid, pix_index} !== e) begin
                    bad++;
                    $display("FAIL %s y=%0d x=%0d: got valid=%0b idx=%h, required valid=%0b idx=%h",
                             name, y, c - 2, pix_valid, pix_index, e[PIX_W], e[PIX_W-1:0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++;
        if ({sdram_rd, sdram_addr, pix_index, pix_valid, front_buf, busy, done, underrun} !== '0) begin
            bad++;
            $display("FAIL reset: rd=%0b addr=%h idx=%h pv=%0b fb=%0b busy=%0b done=%0b ur=%0b, required all 0",
                     sdram_rd, sdram_addr, pix_index, pix_valid, front_buf, busy, done, underrun);
        end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_fetch_line();
        ack_div = 3;
        for (int a = 0; a < WPL; a++) exp_q.push_back(FB0 + ADDR_W'(10 * WPL + a));
        set_line(9);
        wait_idle("fetch10");
        check_addrs("fetch10");
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL fetch10 underrun: got %0b, required 0", underrun);
        end
        set_line(10);
        sweep_line(10, FB0, "pix10");
        wait_idle("fetch11");
        got_q.delete();
    endtask

    task automatic test_scale();
        scale_en = 1'b1;
        for (int a = 0; a < WPL; a++) exp_q.push_back(FB0 + ADDR_W'(3 * WPL + a));
        set_line(5);
        wait_idle("scale_t6");
        check_addrs("scale_t6");
        set_line(6);
        repeat (20) begin
            @(negedge clock);
            total++;
            if (busy !== 1'b0 || sdram_rd !== 1'b0) begin
                bad++;
                $display("FAIL scale_t7 idle: busy=%0b rd=%0b, required 0 0", busy, sdram_rd);
            end
        end
        total++;
        if (got_q.size() != 0) begin
            bad++;
            $display("FAIL scale_t7 reads: got %0d, required 0", got_q.size());
        end
        sweep_line(6, FB0, "scale_pix6");
        set_line(7);
        sweep_line(7, FB0, "scale_pix7");
        wait_idle("scale_t8");
        got_q.delete();
        scale_en = 1'b0;
    endtask

    task automatic test_frame_done();
        for (int a = 0; a < WPL; a++) exp_q.push_back(FB0 + ADDR_W'((V_ACTIVE - 1) * WPL + a));
        set_line(V_ACTIVE - 2);
        wait_idle("fetch_last");
        check_addrs("fetch_last");
        @(negedge clock);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_set: got %0b, required 1", done);
        end
        set_line(10);
        repeat (3) @(negedge clock);
        total++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL done_hold: busy=%0b done=%0b, required 0 1", busy, done);
        end
        pulse_frame(1'b0);
        total++;
        if (done !== 1'b0 || front_buf !== 1'b0) begin
            bad++;
            $display("FAIL done_clear: done=%0b fb=%0b, required 0 0", done, front_buf);
        end
    endtask

    task automatic test_flip();
        pulse_frame(1'b1);
        total++;
        if (front_buf !== 1'b1) begin
            bad++;
            $display("FAIL flip1: front_buf=%0b, required 1", front_buf);
        end
        for (int a = 0; a < WPL; a++) exp_q.push_back(FB1 + ADDR_W'(a));
        set_line(V_TOTAL - 1);
        wait_idle("flip_fetch0");
        check_addrs("flip_fetch0");
        pulse_frame(1'b0);
        total++;
        if (front_buf !== 1'b1) begin
            bad++;
            $display("FAIL flip_hold: front_buf=%0b, required 1", front_buf);
        end
        set_line(0);
        sweep_line(0, FB1, "flip_pix0");
        wait_idle("flip_fetch1");
        got_q.delete();
        pulse_frame(1'b1);
        total++;
        if (front_buf !== 1'b0) begin
            bad++;
            $display("FAIL flip_back: front_buf=%0b, required 0", front_buf);
        end
    endtask

    task automatic test_underrun();
        ack_div = 0;
        set_line(20);
        repeat (60) @(negedge clock);
        total++;
        if (sdram_rd !== 1'b1 || sdram_addr !== FB0 + ADDR_W'(21 * WPL) || underrun !== 1'b0) begin
            bad++;
            $display("FAIL stall_req: rd=%0b addr=%h ur=%0b, required 1 %h 0",
                     sdram_rd, sdram_addr, underrun, FB0 + ADDR_W'(21 * WPL));
        end
        set_line(21);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        total++;
        if (underrun !== 1'b1 || sdram_rd !== 1'b1 || sdram_addr !== FB0 + ADDR_W'(22 * WPL)) begin
            bad++;
            $display("FAIL underrun_restart: ur=%0b rd=%0b addr=%h, required 1 1 %h",
                     underrun, sdram_rd, sdram_addr, FB0 + ADDR_W'(22 * WPL));
        end
        pulse_frame(1'b0);
        total++;
        if (underrun !== 1'b0 || sdram_rd !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL underrun_clear: ur=%0b rd=%0b busy=%0b, required 0 0 0", underrun, sdram_rd, busy);
        end
    endtask

    task automatic test_wait_and_reset();
        @(posedge clock); #1;
        sdram_wait = 1'b1;
        draw_y = 10'd30;
        @(posedge clock);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            total++;
            if (busy !== 1'b1 || sdram_rd !== 1'b0) begin
                bad++;
                $display("FAIL wait_hold cycle %0d: busy=%0b rd=%0b, required 1 0", i, busy, sdram_rd);
            end
            @(posedge clock);
        end
        #1;
        sdram_wait = 1'b0;
        @(posedge clock);
        @(negedge clock);
        total++;
        if (sdram_rd !== 1'b1 || sdram_addr !== FB0 + ADDR_W'(31 * WPL)) begin
            bad++;
            $display("FAIL wait_release: rd=%0b addr=%h, required 1 %h", sdram_rd, sdram_addr, FB0 + ADDR_W'(31 * WPL));
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        total++;
        if ({sdram_rd, sdram_addr, pix_index, pix_valid, front_buf, busy, done, underrun} !== '0) begin
            bad++;
            $display("FAIL reset_in_req: rd=%0b addr=%h busy=%0b ur=%0b, required all 0",
                     sdram_rd, sdram_addr, busy, underrun);
        end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        draw_x     = 10'd1000;
        draw_y     = 10'd500;
        new_frame  = 1'b0;
        flip_req   = 1'b0;
        scale_en   = 1'b0;
        sdram_wait = 1'b0;
        test_reset();
        test_fetch_line();
        test_scale();
        test_frame_done();
        test_flip();
        test_underrun();
        test_wait_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
